lsu_mem_ctrl: RTL



---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_mem_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and RV32I funct3 encodings for the load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational load extension, sub-word store merge and funct3 legality.
// Byte 0 of i_word always belongs to the request address, so no lane
// shifting is required; only extension and low-byte replacement.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_we,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_word,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_load_data,
  output logic [WIDTH-1:0] o_store_word,
  output logic             o_illegal
);

  // Decode size/sign and build both the extended load and the merged store.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_load_data  = '0;
    o_store_word = i_wdata;
    o_illegal    = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_B:    o_store_word = {i_word[WIDTH-1:8], i_wdata[7:0]};
        F3_H:    o_store_word = {i_word[WIDTH-1:16], i_wdata[15:0]};
        F3_W:    o_store_word = i_wdata;
        default: o_illegal    = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_B:    o_load_data = {{(WIDTH-8){i_word[7]}}, i_word[7:0]};
        F3_BU:   o_load_data = {{(WIDTH-8){1'b0}}, i_word[7:0]};
        F3_H:    o_load_data = {{(WIDTH-16){i_word[15]}}, i_word[15:0]};
        F3_HU:   o_load_data = {{(WIDTH-16){1'b0}}, i_word[15:0]};
        F3_W:    o_load_data = i_word;
        default: o_illegal   = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the CPU memory stage and a byte-addressed,
// little-endian RAM that reads combinationally and always writes 4 bytes.
// Sub-word stores use read-modify-write. All outputs are registered.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_rdata_o,
  output logic             resp_err_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  state_t           r_state;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_wdata;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_a;   // doubles as the latched request address
  logic [WIDTH-1:0] r_mem_wd;

  logic             w_idle;
  logic             w_accept;
  logic             w_fault;
  logic             w_we;
  logic [2:0]       w_funct3;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_store_word;
  logic             w_illegal;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid_i && r_req_ready;
  assign w_fault  = |req_addr_i[WIDTH-1:ADDR_W];

  // Legality is judged on the live request in IDLE; extension and merge
  // work on the latched request while the RAM word is on mem_rd_i in RD.
  assign w_we     = w_idle ? req_we_i     : r_we;
  assign w_funct3 = w_idle ? req_funct3_i : r_funct3;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .i_we         (w_we),
    .i_funct3     (w_funct3),
    .i_word       (mem_rd_i),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word),
    .o_illegal    (w_illegal)
  );

  // Request/response FSM; every output is updated on the transition into
  // the state that presents it. The RAM word is consumed straight from
  // mem_rd_i on leaving RD, so the merged store is registered into mem_wd.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_a      <= '0;
      r_mem_wd     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, independent of statement order.
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= req_we_i;
            r_funct3    <= req_funct3_i;
            r_wdata     <= req_wdata_i;
            r_req_ready <= 1'b0;
            if (w_illegal || w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= '0;
            end else if (req_we_i && (req_funct3_i == F3_W)) begin
              r_state  <= WR;
              r_mem_a  <= req_addr_i;
              r_mem_we <= 1'b1;
              r_mem_wd <= req_wdata_i;
            end else begin
              r_state <= RD;
              r_mem_a <= req_addr_i;
            end
          end
        end
        RD: begin
          if (r_we) begin
            r_state  <= WR;
            r_mem_we <= 1'b1;
            r_mem_wd <= w_store_word;
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_load_data;
            r_err        <= 1'b0;
          end
        end
        WR: begin
          r_state      <= RESP;
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_rdata      <= '0;
          r_err        <= 1'b0;
        end
        RESP: begin
          if (resp_ready_i) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rdata      <= '0;
            r_err        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
  assign mem_we_o     = r_mem_we;
  assign mem_a_o      = r_mem_a;
  assign mem_wd_o     = r_mem_wd;

endmodule
